fpu_add_pipe: RTL and testbench
===============================

FPU_ADD_PIPE -- requirements
Module: fpu_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 11, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 52, stored fraction width; operand width W = 1+EXP_W+MANT_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the opaque request tag.
REQ-004 SHALL have port i_clk, input, 1: clock, all state updates on rising edge.
REQ-005 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, 1: request present this cycle.
REQ-007 SHALL have port i_op, input, 3: 0 add, 1 sub, 2 eq, 3 lt, 4 le, 5 max, 6 min, 7 reserved.
REQ-008 SHALL have ports i_a and i_b, input, W: IEEE-754-style operands.
REQ-009 SHALL have port i_tag, input, TAG_W: returned unchanged with the result.
REQ-010 SHALL have port o_valid, output, 1: result valid, exactly one cycle per accepted request.
REQ-011 SHALL have port o_res, output, W: result; compares return 0/1 in bit 0, upper bits zero.
REQ-012 SHALL have port o_tag, output, TAG_W: tag of the request being returned.
REQ-013 SHALL have port o_illegal_op, output, 1: NaN operand, inf-inf, or reserved op.
REQ-014 SHALL have port o_overflow, output, 1: add/sub result rounded to infinity from finite operands.
REQ-015 SHALL have port o_busy, output, 1: OR of all stage-valid bits.

Function
REQ-016 SHALL accept a request every cycle i_valid=1 (no backpressure, throughput 1/cycle).
REQ-017 SHALL return each result exactly 4 cycles after acceptance (o_valid at edge N+4), in issue order, stages: unpack/compare, align, add/sub, normalise/round.
REQ-018 Alignment SHALL shift the smaller-exponent mantissa right by the exponent difference, collapsing shifted-out bits into guard/round/sticky; differences above MANT_W+3 SHALL leave only sticky.
REQ-019 Rounding SHALL be round-to-nearest-even; mantissa carry-out on rounding SHALL increment the exponent.
REQ-020 Exact zero sum of opposite-sign operands SHALL give +0; (-0)+(-0) SHALL give -0.
REQ-021 Any NaN operand to add/sub SHALL return canonical quiet NaN (sign 0, exp all ones, fraction MSB only) with o_illegal_op=1.
REQ-022 inf + (-inf) (incl. sub of same-sign infinities) SHALL return canonical NaN, o_illegal_op=1.
REQ-023 Exponent reaching all ones after rounding SHALL return signed infinity and o_overflow=1; infinite operands SHALL NOT set o_overflow.
REQ-024 eq/lt/le SHALL treat +0 and -0 as equal; any NaN operand SHALL return 0 and o_illegal_op=1.
REQ-025 max/min SHALL order -0 below +0; one NaN operand returns the other operand, both NaN returns canonical NaN; o_illegal_op=1 in both cases.
REQ-026 Reserved op SHALL return 0 with o_illegal_op=1.
REQ-027 Output fields other than o_valid SHALL hold their last value when o_valid=0.

Reset
REQ-028 i_rst=1 SHALL immediately clear all stage-valid bits, o_valid, o_busy, o_illegal_op, o_overflow, o_res and o_tag to 0.
REQ-029 Requests in flight at reset SHALL be discarded; none SHALL emerge after release.
REQ-030 A request with i_valid=1 in the first cycle after release SHALL be accepted normally.

Configuration
REQ-031 With macro FPU_ADD_PIPE_SUBNORMAL_EN defined, subnormal operands and results SHALL be computed exactly per IEEE-754 (gradual underflow).
REQ-032 Without FPU_ADD_PIPE_SUBNORMAL_EN, subnormal operands SHALL be read as same-signed zero and subnormal results SHALL be flushed to same-signed zero; latency unchanged.

Verification (defaults EXP_W=11, MANT_W=52)
REQ-033 add 0x3FF0000000000000 + 0x4000000000000000, tag 3 -> 4 cycles later o_res=0x4008000000000000, o_tag=3, flags 0.
REQ-034 Back-to-back: add(1.0,2.0) tag1, sub(1.0,1.0) tag2, lt(0x8000000000000000,0x0) tag3 -> consecutive o_valid with 0x4008000000000000/1, 0x0/2, 0x0/3.
REQ-035 add 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF -> o_res=0x7FF0000000000000, o_overflow=1.
REQ-036 sub 0x7FF0000000000000 - 0x7FF0000000000000 -> o_res=0x7FF8000000000000, o_illegal_op=1; min(0x7FF8000000000000, 0x3FF0000000000000) -> 0x3FF0000000000000, o_illegal_op=1.
REQ-037 add 0x0000000000000001 + 0x0000000000000001 -> 0x0000000000000002 with FPU_ADD_PIPE_SUBNORMAL_EN, 0x0 without.
REQ-038 Issue 3 requests, assert i_rst one cycle mid-flight -> o_valid and o_busy 0 immediately, no stale results afterwards; new request after release returns correctly.

Source files
------------

// File: rtl/fpu_add_pipe.sv
// rtl/fpu_add_pipe.sv - 4-stage IEEE-754 style add/sub/compare/min/max pipeline, result 4 cycles after issue
// Define FPU_ADD_PIPE_SUBNORMAL_EN for gradual underflow; otherwise subnormal operands/results flush to signed zero.
module fpu_add_pipe #(
  parameter int EXP_W  = 11,
  parameter int MANT_W = 52,
  parameter int TAG_W  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [2:0]                  i_op,
  input  logic [EXP_W+MANT_W:0]       i_a,
  input  logic [EXP_W+MANT_W:0]       i_b,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_valid,
  output logic [EXP_W+MANT_W:0]       o_res,
  output logic [TAG_W-1:0]            o_tag,
  output logic                        o_illegal_op,
  output logic                        o_overflow,
  output logic                        o_busy
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int M4  = MANT_W + 4;   // hidden bit, fraction, guard, round, sticky
  localparam int EW2 = EXP_W + 2;
  localparam int LZW = $clog2(M4 + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  function automatic logic [W-1:0] flush_sub(input logic [W-1:0] x);
`ifdef FPU_ADD_PIPE_SUBNORMAL_EN
    return x;
`else
    return (x[W-2:MANT_W] == '0) ? {x[W-1], {(W-1){1'b0}}} : x;
`endif
  endfunction

  logic                v1, v2, v3, v4;
  logic [TAG_W-1:0]    tag1, tag2, tag3, tag4;
  logic                sp1, sp2, sp3, sp4, ill1, ill2, ill3, ill4;
  logic [W-1:0]        res1, res2, res3, res4;
  logic                sg1, sg2, sg3, sg4, sub1, sub2, sub3;
  logic [EXP_W-1:0]    e1, e2, e3, d1;
  logic [EW2-1:0]      e4;
  logic [MANT_W:0]     mb1, ms1;
  logic [M4-1:0]       xb2, xs2, n4;
  logic [M4:0]         sum3;

  // Stage 1: classify, resolve specials and compares, order operands by magnitude
  logic [W-1:0]        fa, fb, key_a, key_b, sp_res;
  logic                a_nan, b_nan, a_inf, b_inf, b_sign, a_big, both_zero, eq_ab, lt_ab, sp, sp_ill;
  logic [EXP_W-1:0]    ea, eb;
  logic [MANT_W:0]     ma, mb;

  always_comb begin
    fa = flush_sub(i_a);
    fb = flush_sub(i_b);
    a_inf = (fa[W-2:MANT_W] == EMAX) && (fa[MANT_W-1:0] == '0);
    a_nan = (fa[W-2:MANT_W] == EMAX) && (fa[MANT_W-1:0] != '0);
    b_inf = (fb[W-2:MANT_W] == EMAX) && (fb[MANT_W-1:0] == '0);
    b_nan = (fb[W-2:MANT_W] == EMAX) && (fb[MANT_W-1:0] != '0);
    b_sign = fb[W-1] ^ (i_op == 3'd1);
    a_big = fa[W-2:0] >= fb[W-2:0];
    both_zero = (fa[W-2:0] == '0) && (fb[W-2:0] == '0);
    key_a = fa[W-1] ? ~fa : {1'b1, fa[W-2:0]};
    key_b = fb[W-1] ? ~fb : {1'b1, fb[W-2:0]};
    eq_ab = (key_a == key_b) || both_zero;
    lt_ab = (key_a < key_b) && !both_zero;
    ea = (fa[W-2:MANT_W] == '0) ? EXP_W'(1) : fa[W-2:MANT_W];
    eb = (fb[W-2:MANT_W] == '0) ? EXP_W'(1) : fb[W-2:MANT_W];
    ma = {fa[W-2:MANT_W] != '0, fa[MANT_W-1:0]};
    mb = {fb[W-2:MANT_W] != '0, fb[MANT_W-1:0]};
    sp = 1'b1;
    sp_ill = 1'b0;
    sp_res = '0;
    case (i_op)
      3'd0, 3'd1: begin
        if (a_nan || b_nan || (a_inf && b_inf && (fa[W-1] != b_sign))) begin
          sp_ill = 1'b1;
          sp_res = QNAN;
        end else if (a_inf) sp_res = fa;
        else if (b_inf) sp_res = {b_sign, fb[W-2:0]};
        else sp = 1'b0;
      end
      3'd2, 3'd3, 3'd4: begin
        sp_ill = a_nan || b_nan;
        sp_res[0] = !sp_ill && ((i_op == 3'd2) ? eq_ab : (i_op == 3'd3) ? lt_ab : (lt_ab || eq_ab));
      end
      3'd5, 3'd6: begin
        sp_ill = a_nan || b_nan;
        if (a_nan && b_nan) sp_res = QNAN;
        else if (a_nan) sp_res = fb;
        else if (b_nan) sp_res = fa;
        else sp_res = ((key_a > key_b) == (i_op == 3'd5)) ? fa : fb;
      end
      default: sp_ill = 1'b1;
    endcase
  end

  // Stage 2: align smaller operand, collapsing shifted-out bits into sticky
  logic [M4-1:0] sh_ext, lost, aligned;
  always_comb begin
    sh_ext = {ms1, 3'b000};
    lost = sh_ext & ~({M4{1'b1}} << d1);
    aligned = (sh_ext >> d1) | {{(M4-1){1'b0}}, |lost};
  end

  // Stage 3 add/sub and stage 4 normalisation, with exponent floored at 1 for subnormals
  logic [M4:0]     sum;
  logic [LZW-1:0]  lz;
  logic [EW2-1:0]  lz_w, room, shamt, e_n;
  logic [M4-1:0]   n_norm;
  always_comb begin
    sum = sub2 ? ({1'b0, xb2} - {1'b0, xs2}) : ({1'b0, xb2} + {1'b0, xs2});
    lz = LZW'(M4);
    for (int i = 0; i < M4; i++) if (sum3[i]) lz = LZW'(M4 - 1 - i);
    lz_w = EW2'(lz);
    room = EW2'(e3) - EW2'(1);
    shamt = (lz_w < room) ? lz_w : room;
    if (sum3[M4]) begin
      n_norm = {sum3[M4:2], sum3[1] | sum3[0]};
      e_n = EW2'(e3) + EW2'(1);
    end else begin
      n_norm = sum3[M4-1:0] << shamt;
      e_n = EW2'(e3) - shamt;
    end
  end

  // Output stage: round to nearest even, pack, detect overflow
  logic [MANT_W+1:0] rnd;
  logic [EW2-1:0]    e_f;
  logic [W-1:0]      fin_res;
  logic              fin_ovf;
  always_comb begin
    rnd = {1'b0, n4[M4-1:3]} + (MANT_W+2)'(n4[2] & (n4[1] | n4[0] | n4[3]));
    e_f = rnd[MANT_W+1] ? e4 + EW2'(1) : (rnd[MANT_W] ? e4 : '0);
    fin_ovf = !sp4 && (e_f >= EW2'(EMAX));
    fin_res = {sg4, e_f[EXP_W-1:0], rnd[MANT_W-1:0]};
`ifndef FPU_ADD_PIPE_SUBNORMAL_EN
    if (e_f == '0) fin_res = {sg4, {(W-1){1'b0}}};
`endif
    if (fin_ovf) fin_res = {sg4, EMAX, {MANT_W{1'b0}}};
    if (sp4) fin_res = res4;
  end

  always_ff @(posedge i_clk) begin
    tag1 <= i_tag;  sp1 <= sp;   ill1 <= sp_ill;  res1 <= sp_res;
    sg1  <= a_big ? fa[W-1] : b_sign;
    sub1 <= fa[W-1] ^ b_sign;
    e1   <= a_big ? ea : eb;
    d1   <= a_big ? (ea - eb) : (eb - ea);
    mb1  <= a_big ? ma : mb;
    ms1  <= a_big ? mb : ma;
    tag2 <= tag1;   sp2 <= sp1;  ill2 <= ill1;    res2 <= res1;
    sg2  <= sg1;    sub2 <= sub1; e2 <= e1;
    xb2  <= {mb1, 3'b000};
    xs2  <= aligned;
    tag3 <= tag2;   sp3 <= sp2;  ill3 <= ill2;    res3 <= res2;
    sg3  <= sg2;    sub3 <= sub2; e3 <= e2;       sum3 <= sum;
    tag4 <= tag3;   sp4 <= sp3;  ill4 <= ill3;    res4 <= res3;
    sg4  <= (sum3 == '0 && sub3) ? 1'b0 : sg3;
    e4   <= e_n;
    n4   <= n_norm;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      o_valid <= 1'b0;
      o_res <= '0;
      o_tag <= '0;
      o_illegal_op <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      v1 <= i_valid; v2 <= v1; v3 <= v2; v4 <= v3;
      o_valid <= v4;
      if (v4) begin
        o_res <= fin_res;
        o_tag <= tag4;
        o_illegal_op <= ill4;
        o_overflow <= fin_ovf;
      end
    end
  end

  assign o_busy = v1 | v2 | v3 | v4 | o_valid;
endmodule

// File: tb/tb_fpu_add_pipe.sv
// tb/tb_fpu_add_pipe.sv - self-checking bench for fpu_add_pipe using a real-arithmetic reference model
// Honours FPU_ADD_PIPE_SUBNORMAL_EN the same way as the design.
module tb_fpu_add_pipe;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [2:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic [3:0]  tag = '0;
  logic        o_valid, o_ill, o_ovf, o_busy;
  logic [63:0] o_res;
  logic [3:0]  o_tag;

  always #5 clk = ~clk;

  fpu_add_pipe #(.EXP_W(11), .MANT_W(52), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op(op), .i_a(a), .i_b(b), .i_tag(tag),
    .o_valid(o_valid), .o_res(o_res), .o_tag(o_tag), .o_illegal_op(o_ill),
    .o_overflow(o_ovf), .o_busy(o_busy));

  int checks = 0, fails = 0, edge_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] ftz(input logic [63:0] x);
`ifdef FPU_ADD_PIPE_SUBNORMAL_EN
    return x;
`else
    return (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
`endif
  endfunction

  function automatic logic is_nan(input logic [63:0] x);
    return x[62:52] == 11'h7FF && x[51:0] != 52'd0;
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return x[62:52] == 11'h7FF && x[51:0] == 52'd0;
  endfunction

  // returns {illegal, overflow, result}; arithmetic done in host double precision
  function automatic logic [65:0] ref_model(input logic [2:0] o, input logic [63:0] xa, input logic [63:0] xb);
    logic [63:0] x, y, r;
    logic ill, ovf;
    real rx, ry;
    x = ftz(xa);
    y = ftz(xb);
    if (o == 3'd1) y[63] = ~y[63];
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    ill = 1'b0; ovf = 1'b0; r = 64'd0;
    case (o)
      3'd0, 3'd1: begin
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && x[63] != y[63])) begin
          ill = 1'b1; r = QNAN;
        end else begin
          r = ftz($realtobits(rx + ry));
          ovf = !is_inf(x) && !is_inf(y) && is_inf(r);
        end
      end
      3'd2, 3'd3, 3'd4: begin
        if (is_nan(x) || is_nan(y)) ill = 1'b1;
        else r[0] = (o == 3'd2) ? (rx == ry) : (o == 3'd3) ? (rx < ry) : (rx <= ry);
      end
      3'd5, 3'd6: begin
        if (is_nan(x) || is_nan(y)) begin
          ill = 1'b1;
          r = (is_nan(x) && is_nan(y)) ? QNAN : is_nan(x) ? y : x;
        end else if (rx > ry) r = (o == 3'd5) ? x : y;
        else if (rx < ry) r = (o == 3'd5) ? y : x;
        else r = (x[63] == y[63]) ? x : (((o == 3'd5) == x[63]) ? y : x);
      end
      default: ill = 1'b1;
    endcase
    return {ill, ovf, r};
  endfunction

  typedef struct {
    int          due;
    logic [63:0] res;
    logic [3:0]  tag;
    logic        ill;
    logic        ovf;
  } exp_t;
  exp_t q[$];

  logic [65:0] m;
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      if (valid) begin
        m = ref_model(op, a, b);
        q.push_back('{due: edge_cnt + 4, res: m[63:0], tag: tag, ill: m[65], ovf: m[64]});
      end
      edge_cnt++;
    end
  end

  logic [63:0] hold_res = '0;
  logic [3:0]  hold_tag = '0;
  logic        hold_ill = 1'b0, hold_ovf = 1'b0;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset o_valid", 64'(o_valid), 64'd0);
      chk("reset o_busy", 64'(o_busy), 64'd0);
      chk("reset o_res", o_res, 64'd0);
      chk("reset o_tag", 64'(o_tag), 64'd0);
      chk("reset flags", {62'd0, o_ill, o_ovf}, 64'd0);
      hold_res = '0; hold_tag = '0; hold_ill = 1'b0; hold_ovf = 1'b0;
    end else begin
      chk("o_busy", 64'(o_busy), 64'(q.size() != 0));
      if (q.size() > 0 && q[0].due == edge_cnt - 1) begin
        e = q.pop_front();
        chk("o_valid", 64'(o_valid), 64'd1);
        chk("o_res", o_res, e.res);
        chk("o_tag", 64'(o_tag), 64'(e.tag));
        chk("o_illegal_op", 64'(o_ill), 64'(e.ill));
        chk("o_overflow", 64'(o_ovf), 64'(e.ovf));
        hold_res = e.res; hold_tag = e.tag; hold_ill = e.ill; hold_ovf = e.ovf;
      end else begin
        chk("idle o_valid", 64'(o_valid), 64'd0);
        chk("hold fields", {o_res ^ hold_res}, 64'd0);
        chk("hold tag/flags", {58'd0, o_tag, o_ill, o_ovf}, {58'd0, hold_tag, hold_ill, hold_ovf});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic [3:0] t);
    op = o; a = x; b = y; tag = t; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_check(input string name, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                             input logic [3:0] t, input logic [63:0] r, input logic ill, input logic ovf);
    issue(o, x, y, t);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, " valid"}, 64'(o_valid), 64'd1);
    chk({name, " res"}, o_res, r);
    chk({name, " tag"}, 64'(o_tag), 64'(t));
    chk({name, " flags"}, {62'd0, o_ill, o_ovf}, {62'd0, ill, ovf});
  endtask

  function automatic logic [63:0] rand_frac();
    return {12'd0, 20'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [63:0] gen_operand(input logic [63:0] other);
    logic [63:0] x;
    x = {1'($urandom), 11'($urandom_range(1, 2046)), rand_frac()[51:0]};
    case ($urandom_range(0, 11))
      0: x[62:0] = '0;
      1: x[62:0] = {11'h7FF, 52'd0};
      2: x[62:0] = {11'h7FF, 52'(rand_frac() | 64'd1)};
      3: x[62:52] = 11'd0;
      4: x[62:52] = 11'($urandom_range(2040, 2046));
      5: begin x = other; x[63] = 1'($urandom); x[2:0] = 3'($urandom); end
      6: begin x = other; x[62:52] = other[62:52] + 11'($urandom_range(0, 3)); end
      7: x[62:52] = 11'($urandom_range(1, 3));
      default: ;
    endcase
    return x;
  endfunction

  logic [63:0] x, y, prev;
  int r;
  initial begin
    idle(3);
    rst = 1'b0;

    chk("model 1+2", ref_model(3'd0, 64'h3FF0000000000000, 64'h4000000000000000), {2'b00, 64'h4008000000000000});
    chk("model 1-1", ref_model(3'd1, 64'h3FF0000000000000, 64'h3FF0000000000000), {2'b00, 64'h0});
    chk("model -0<0", ref_model(3'd3, 64'h8000000000000000, 64'h0), {2'b00, 64'h0});
    chk("model ovf", ref_model(3'd0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF), {2'b01, 64'h7FF0000000000000});
    chk("model inf-inf", ref_model(3'd1, 64'h7FF0000000000000, 64'h7FF0000000000000), {2'b10, QNAN});
    chk("model min nan", ref_model(3'd6, QNAN, 64'h3FF0000000000000), {2'b10, 64'h3FF0000000000000});
    chk("model max zeros", ref_model(3'd5, 64'h8000000000000000, 64'h0), {2'b00, 64'h0});

    issue_check("add 1+2", 3'd0, 64'h3FF0000000000000, 64'h4000000000000000, 4'd3, 64'h4008000000000000, 1'b0, 1'b0);
    issue(3'd0, 64'h3FF0000000000000, 64'h4000000000000000, 4'd1);
    issue(3'd1, 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd2);
    issue(3'd3, 64'h8000000000000000, 64'h0, 4'd3);
    idle(6);
    issue_check("overflow", 3'd0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 4'd4, 64'h7FF0000000000000, 1'b0, 1'b1);
    issue_check("inf-inf", 3'd1, 64'h7FF0000000000000, 64'h7FF0000000000000, 4'd5, QNAN, 1'b1, 1'b0);
    issue_check("min nan", 3'd6, QNAN, 64'h3FF0000000000000, 4'd6, 64'h3FF0000000000000, 1'b1, 1'b0);
    issue_check("neg zeros", 3'd0, 64'h8000000000000000, 64'h8000000000000000, 4'd7, 64'h8000000000000000, 1'b0, 1'b0);
    issue_check("tie even", 3'd0, 64'h3FF0000000000000, 64'h3CA0000000000000, 4'd8, 64'h3FF0000000000000, 1'b0, 1'b0);
    issue_check("reserved", 3'd7, 64'h3FF0000000000000, 64'h3FF0000000000000, 4'd9, 64'h0, 1'b1, 1'b0);
`ifdef FPU_ADD_PIPE_SUBNORMAL_EN
    issue_check("subnormal", 3'd0, 64'h1, 64'h1, 4'd10, 64'h2, 1'b0, 1'b0);
`else
    issue_check("subnormal", 3'd0, 64'h1, 64'h1, 4'd10, 64'h0, 1'b0, 1'b0);
`endif

    issue(3'd0, 64'h3FF0000000000000, 64'h4000000000000000, 4'd1);
    issue(3'd1, 64'h4000000000000000, 64'h3FF0000000000000, 4'd2);
    issue(3'd5, 64'h4000000000000000, 64'h3FF0000000000000, 4'd3);
    rst = 1'b1;
    #1;
    chk("mid reset o_valid", 64'(o_valid), 64'd0);
    chk("mid reset o_busy", 64'(o_busy), 64'd0);
    idle(1);
    rst = 1'b0;
    issue_check("after reset", 3'd1, 64'h4008000000000000, 64'h3FF0000000000000, 4'd11, 64'h4000000000000000, 1'b0, 1'b0);
    idle(6);

    prev = 64'h3FF0000000000000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 11);
        x = gen_operand(prev);
        y = gen_operand(x);
        op = (r < 6) ? 3'(r % 2) : 3'(r - 4);
        a = x; b = y; tag = 4'($urandom); valid = 1'b1;
        prev = y;
      end else valid = 1'b0;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
